seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Executes logic, add/sub, shift and rotate ops in one cycle.
- Executes signed multiply (radix-2 Booth) and signed divide (restoring) iteratively.
- Uses a start/busy/done handshake and a double-width HI/LO result, so the datapath control unit can stall on long ops.

Parameters:
- DATA_W, 32, operand/result-half width; must be ≥4 and a power of two.
- OP_W, 5, opcode select width.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  OP_W  operation select.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results valid and held from this cycle.
- result_lo  out  DATA_W  low result (quotient for DIV).
- result_hi  out  DATA_W  high result (product high half for MUL, remainder for DIV, else 0).
- carry_out  out  1  ADD: carry from MSB; SUB: no-borrow (a ≥ b unsigned); else 0.
- div_by_zero  out  1  set with done for DIV with b=0; else 0.

Behaviour:
- Reset: asynchronous on clr_n=0.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-operation aborts it; no done is produced.
- Accept: start=1 while busy=0 latches op, a and b.
  - Later input changes have no effect.
  - start while busy=1 is ignored (not queued).
- FSM states: IDLE, ITER, FIN.
  - IDLE→FIN for single-cycle ops, illegal ops and DIV with b=0.
  - IDLE→ITER for MUL, and for DIV with b≠0.
  - ITER→FIN after exactly DATA_W iterations (counter, DATA_W-1 down to 0).
  - FIN→IDLE unconditionally; done=1 in FIN.
- Latency (start accepted at edge t):
  - single-cycle ops: done at t+1.
  - MUL and DIV: done at t+DATA_W+1.
  - Back-to-back start is allowed in the cycle done is high, because busy=0 in FIN.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 NOT a; 6 NEG a (two's complement).
  - 7 SHL; 8 SHR logical; 9 SHRA arithmetic; 10 ROL; 11 ROR.
  - Shift/rotate amount is b[log2(DATA_W)-1:0]; amount 0 returns a unchanged.
  - 12 MUL: signed a×b; full 2·DATA_W product to {hi,lo}.
  - 13 DIV: signed a/b; quotient truncates toward zero; remainder takes the sign of the dividend.
  - 14..2^OP_W-1 illegal: lo=hi=0, flags 0, done at t+1.
- Width rules: ADD/SUB wrap modulo 2^DATA_W. The most-negative value ÷ -1 gives lo=most-negative, hi=0, no error.
- DIV by zero: lo=all ones, hi=a, div_by_zero=1.
- Hold: results and flags hold from done until the next done; busy does not clear them.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- Defined: adds output ports zero (1b), negative (1b) and overflow (1b), updated with done.
  - zero: {hi,lo}==0 for MUL, else lo==0.
  - negative: MSB of hi for MUL, else MSB of lo.
  - overflow: signed overflow for ADD/SUB/NEG; for MUL, product not representable in DATA_W bits; else 0.
- Undefined: the ports do not exist and no flag logic is generated.

Test Plan:
- ADD a=5, b=2, start at t → done pulse at t+1, lo=7, hi=0, carry_out=0; busy never asserts.
- SUB a=2, b=5 → lo=0xFFFFFFFD, carry_out=0; then a=5, b=2 → lo=3, carry_out=1.
- MUL a=-3, b=7 → busy for 32 cycles, done at t+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. Assert start with op=0 at t+5: ignored, result unchanged.
- DIV a=-17, b=5 → done at t+33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). DIV a=9, b=0 → done at t+1, lo=0xFFFFFFFF, hi=9, div_by_zero=1.
- ROR a=0x80000001, b=1 → lo=0xC0000000. SHRA a=0x80000000, b=31 → lo=0xFFFFFFFF. Op 20 → lo=hi=0, done at t+1.
- Start MUL, pull clr_n low at t+10 for 1 cycle → all outputs 0 immediately, no done. The next ADD 1+1 completes normally with lo=2.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake and HI/LO results.
// Logic, add/sub, shift and rotate ops finish in one cycle. Signed multiply
// (radix-2 Booth) and signed divide (restoring) take DATA_W iterations.
// Optional macro SEQ_ALU_FLAGS_EN adds zero/negative/overflow outputs.
module seq_alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output logic              carry_out,
  output logic              div_by_zero
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic              zero,
  output logic              negative,
  output logic              overflow
`endif
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int M    = DATA_W - 1;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SHRA = OP_W'(9);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ROR  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(13);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t            state, state_nx;
  logic [SH_W-1:0]   cnt;
  logic              is_mul_q;
  logic [DATA_W:0]   acc, mreg;
  logic [DATA_W-1:0] qreg;
  logic              qm1, neg_q, neg_r;

  logic              accept, is_mul_in, go_iter;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [SH_W-1:0]   sh;
  logic [DATA_W:0]   add_w, sub_w;
  logic [DATA_W-1:0] sc_lo, sc_hi;
  logic              sc_c, sc_dbz;

  logic [DATA_W:0]   booth_sum, div_sh, div_tr, acc_nx;
  logic [DATA_W-1:0] q_nx, it_lo, it_hi;
  logic              qm1_nx;

  assign accept    = start && (state != ITER);
  assign is_mul_in = (op == OP_MUL);
  assign go_iter   = is_mul_in || ((op == OP_DIV) && (b != '0));
  assign busy      = (state == ITER);
  assign done      = (state == FIN);

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: FIN releases busy, so a new start is accepted there too
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: state_nx = accept ? (go_iter ? ITER : FIN) : IDLE;
      ITER:      if (cnt == '0) state_nx = FIN;
      default:   state_nx = IDLE;
    endcase
  end

  // Single-cycle results, computed straight from the accepted inputs
  always_comb begin
    sh     = b[SH_W-1:0];
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = {1'b0, a} - {1'b0, b};
    abs_a  = a[M] ? ('0 - a) : a;
    abs_b  = b[M] ? ('0 - b) : b;
    sc_lo  = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_dbz = 1'b0;
    case (op)
      OP_ADD:  begin sc_lo = add_w[M:0]; sc_c = add_w[DATA_W];  end
      OP_SUB:  begin sc_lo = sub_w[M:0]; sc_c = ~sub_w[DATA_W]; end
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_XOR:  sc_lo = a ^ b;
      OP_NOT:  sc_lo = ~a;
      OP_NEG:  sc_lo = '0 - a;
      OP_SHL:  sc_lo = a << sh;
      OP_SHR:  sc_lo = a >> sh;
      OP_SHRA: sc_lo = $signed(a) >>> sh;
      // a >> DATA_W yields 0, so an amount of 0 returns a unchanged
      OP_ROL:  sc_lo = (a << sh) | (a >> (DATA_W - int'(sh)));
      OP_ROR:  sc_lo = (a >> sh) | (a << (DATA_W - int'(sh)));
      // Only reaches here as a single-cycle op when b == 0
      OP_DIV:  begin sc_lo = '1; sc_hi = a; sc_dbz = 1'b1; end
      default: ;
    endcase
  end

  // One Booth or restoring-division step; it_* is the final result on the last step
  always_comb begin
    booth_sum = acc;
    case ({qreg[0], qm1})
      2'b01:   booth_sum = acc + mreg;
      2'b10:   booth_sum = acc - mreg;
      default: ;
    endcase
    div_sh = {acc[M:0], qreg[M]};
    div_tr = div_sh - mreg;
    acc_nx = acc;
    q_nx   = qreg;
    qm1_nx = 1'b0;
    if (is_mul_q) begin
      acc_nx = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
      q_nx   = {booth_sum[0], qreg[M:1]};
      qm1_nx = qreg[0];
      it_lo  = q_nx;
      it_hi  = acc_nx[M:0];
    end else begin
      if (!div_tr[DATA_W]) begin
        acc_nx = div_tr;
        q_nx   = {qreg[M-1:0], 1'b1};
      end else begin
        acc_nx = div_sh;
        q_nx   = {qreg[M-1:0], 1'b0};
      end
      it_lo = neg_q ? ('0 - q_nx) : q_nx;
      it_hi = neg_r ? ('0 - acc_nx[M:0]) : acc_nx[M:0];
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic sc_ovf;

  // Signed overflow for the single-cycle arithmetic ops
  always_comb begin
    sc_ovf = 1'b0;
    case (op)
      OP_ADD:  sc_ovf = (a[M] == b[M]) && (add_w[M] != a[M]);
      OP_SUB:  sc_ovf = (a[M] != b[M]) && (sub_w[M] != a[M]);
      OP_NEG:  sc_ovf = (a == {1'b1, {(DATA_W-1){1'b0}}});
      default: ;
    endcase
  end
`endif

  // Operand latch, iteration registers and held results
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt         <= '0;
      is_mul_q    <= 1'b0;
      acc         <= '0;
      mreg        <= '0;
      qreg        <= '0;
      qm1         <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      carry_out   <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      zero        <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
`endif
    end else if (accept) begin
      is_mul_q <= is_mul_in;
      cnt      <= SH_W'(DATA_W - 1);
      acc      <= '0;
      qm1      <= 1'b0;
      qreg     <= is_mul_in ? a : abs_a;
      mreg     <= is_mul_in ? {b[M], b} : {1'b0, abs_b};
      neg_q    <= a[M] ^ b[M];
      neg_r    <= a[M];
      if (!go_iter) begin
        result_lo   <= sc_lo;
        result_hi   <= sc_hi;
        carry_out   <= sc_c;
        div_by_zero <= sc_dbz;
`ifdef SEQ_ALU_FLAGS_EN
        zero        <= (sc_lo == '0);
        negative    <= sc_lo[M];
        overflow    <= sc_ovf;
`endif
      end
    end else if (state == ITER) begin
      acc  <= acc_nx;
      qreg <= q_nx;
      qm1  <= qm1_nx;
      cnt  <= cnt - 1'b1;
      if (cnt == '0) begin
        result_lo   <= it_lo;
        result_hi   <= it_hi;
        carry_out   <= 1'b0;
        div_by_zero <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
        zero        <= is_mul_q ? ({it_hi, it_lo} == '0) : (it_lo == '0);
        negative    <= is_mul_q ? it_hi[M] : it_lo[M];
        overflow    <= is_mul_q && (it_hi != {DATA_W{it_lo[M]}});
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against a behavioural
// model built on 64-bit integer arithmetic. Honours SEQ_ALU_FLAGS_EN.
module tb_seq_alu;
  localparam int W  = 32;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          clr_n, start;
  logic [OW-1:0] op;
  logic [W-1:0]  a, b;
  logic          busy, done, carry_out, div_by_zero;
  logic [W-1:0]  result_lo, result_hi;
`ifdef SEQ_ALU_FLAGS_EN
  logic          zero, negative, overflow;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] held_lo, held_hi;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         dbz;
    logic         z;
    logic         n;
    logic         v;
    int           lat;
  } exp_t;

  seq_alu #(.DATA_W(W), .OP_W(OW)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .carry_out(carry_out), .div_by_zero(div_by_zero)
`ifdef SEQ_ALU_FLAGS_EN
    , .zero(zero), .negative(negative), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic out_of_range(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // Reference: plain signed/unsigned 64-bit arithmetic on the operand values
  function automatic exp_t model(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, t, q, r;
    longint unsigned ux, uy;
    int s;
    e  = '{lo: '0, hi: '0, c: 1'b0, dbz: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0, lat: 1};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    s  = int'(uy % 64'(W));
    case (o)
      0: begin t = longint'(ux + uy); e.lo = t[W-1:0]; e.c = (t > 64'sd4294967295); e.v = out_of_range(sx + sy); end
      1: begin e.lo = x - y; e.c = (ux >= uy); e.v = out_of_range(sx - sy); end
      2: e.lo = x & y;
      3: e.lo = x | y;
      4: e.lo = x ^ y;
      5: e.lo = ~x;
      6: begin t = -sx; e.lo = t[W-1:0]; e.v = out_of_range(t); end
      7: e.lo = x << s;
      8: e.lo = x >> s;
      9: e.lo = $signed(x) >>> s;
      10: e.lo = (s == 0) ? x : ((x << s) | (x >> (W - s)));
      11: e.lo = (s == 0) ? x : ((x >> s) | (x << (W - s)));
      12: begin
        t = sx * sy;
        e.lo = t[W-1:0]; e.hi = t[2*W-1:W]; e.v = out_of_range(t); e.lat = W + 1;
      end
      13: begin
        if (y == '0) begin
          e.lo = '1; e.hi = x; e.dbz = 1'b1;
        end else begin
          q = sx / sy; r = sx % sy;
          e.lo = q[W-1:0]; e.hi = r[W-1:0]; e.lat = W + 1;
        end
      end
      default: ;
    endcase
    if (o == 12) begin e.z = ({e.hi, e.lo} == '0); e.n = e.hi[W-1]; end
    else         begin e.z = (e.lo == '0);         e.n = e.lo[W-1]; end
    return e;
  endfunction

  // Present a request for one edge, then scramble inputs to prove they were latched
  task automatic issue(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = OW'(o); a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OW'($urandom); a = $urandom; b = $urandom;
  endtask

  // Wait (bounded) for done, checking busy, latency, results, hold and pulse width
  task automatic finish_op(input string tag, input exp_t e, input int inject_at);
    int lat = 1;
    int busy_bad = 0;
    int hold_bad = 0;
    bit seen = 0;
    while (lat <= 100) begin
      if (done) begin seen = 1; break; end
      if (!busy) busy_bad++;
      if (result_lo !== held_lo || result_hi !== held_hi) hold_bad++;
      if (inject_at != 0 && lat == inject_at) begin start = 1'b1; op = '0; a = 1; b = 1; end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "/done_seen"}, 64'(seen), 64'd1);
    check({tag, "/latency"}, 64'(lat), 64'(e.lat));
    check({tag, "/busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, "/hold_during"}, 64'(hold_bad), 64'd0);
    check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "/lo"}, 64'(result_lo), 64'(e.lo));
    check({tag, "/hi"}, 64'(result_hi), 64'(e.hi));
    check({tag, "/carry"}, 64'(carry_out), 64'(e.c));
    check({tag, "/dbz"}, 64'(div_by_zero), 64'(e.dbz));
`ifdef SEQ_ALU_FLAGS_EN
    check({tag, "/flags"}, 64'({zero, negative, overflow}), 64'({e.z, e.n, e.v}));
`endif
    held_lo = e.lo;
    held_hi = e.hi;
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 64'(done), 64'd0);
    check({tag, "/lo_held"}, 64'(result_lo), 64'(e.lo));
  endtask

  task automatic run(input string tag, input int o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int inject_at);
    exp_t e;
    e = model(o, x, y);
    issue(o, x, y);
    finish_op(tag, e, inject_at);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'h0000_0001;
      4: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e1, e2;
    int dones;
    clr_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    held_lo = '0; held_hi = '0;
    #12;
    check("reset/data", {result_lo, result_hi}, 64'd0);
    check("reset/ctl", 64'({busy, done, carry_out, div_by_zero}), 64'd0);
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); #1;

    run("add_5_2", 0, 32'd5, 32'd2, 0);
    run("sub_2_5", 1, 32'd2, 32'd5, 0);
    run("sub_5_2", 1, 32'd5, 32'd2, 0);
    run("mul_m3_7_inject", 12, -32'sd3, 32'd7, 5);
    check("mul_inject/no_extra_done", 64'(done), 64'd0);
    run("div_m17_5", 13, -32'sd17, 32'd5, 0);
    run("div_9_0", 13, 32'd9, 32'd0, 0);
    run("div_min_m1", 13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("mul_min_min", 12, 32'h8000_0000, 32'h8000_0000, 0);
    run("ror_1", 11, 32'h8000_0001, 32'd1, 0);
    run("rol_0", 10, 32'h1234_5678, 32'd32, 0);
    run("shra_31", 9, 32'h8000_0000, 32'd31, 0);
    run("illegal_20", 20, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 0);
    run("neg_min", 6, 32'h8000_0000, 32'd0, 0);

    // Back-to-back: second start issued in the cycle done is high
    e1 = model(0, 32'd3, 32'd4);
    e2 = model(1, 32'd10, 32'd3);
    issue(0, 32'd3, 32'd4);
    check("b2b/first_done", 64'(done), 64'd1);
    check("b2b/first_lo", 64'(result_lo), 64'(e1.lo));
    held_lo = e1.lo; held_hi = e1.hi;
    issue(1, 32'd10, 32'd3);
    finish_op("b2b_sub", e2, 0);

    // Reset in the middle of a multiply
    issue(12, 32'd1234, 32'd5678);
    repeat (9) begin @(posedge clk); #1; end
    clr_n = 1'b0;
    #1;
    check("midreset/data", {result_lo, result_hi}, 64'd0);
    check("midreset/ctl", 64'({busy, done, carry_out, div_by_zero}), 64'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    held_lo = '0; held_hi = '0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check("midreset/no_done", 64'(dones), 64'd0);
    run("after_reset_add", 0, 32'd1, 32'd1, 0);

    // Randomized sweep, including illegal opcodes
    for (int i = 0; i < 200; i++) begin
      int o;
      o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 31)) : int'($urandom_range(0, 13));
      run($sformatf("rnd%0d_op%0d", i, o), o, pick(), pick(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
